az_sequencer: RTL and testbench
===============================

AZ_SEQUENCER -- requirements
Module: az_sequencer

Interface
REQ-001 Parameter NUM_BITS, 14, width of conditioning_out.
REQ-002 Parameter CNT_W, 24, width of phase duration counters and inputs.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; high = cycle continuously, low = stop at end of current AZ cycle.
REQ-006 azmux_sig  input  4  azmux code {EN,A2,A1,A0} for signal phases.
REQ-007 azmux_zero  input  4  azmux code for zero phases.
REQ-008 himux_sel  input  4  himux code; himux2_sel  input  4  himux2 code.
REQ-009 settle_count  input  CNT_W  settle phase length in clocks.
REQ-010 int_count  input  CNT_W  integrate phase length in clocks.
REQ-011 ack  input  1  clears interrupt_out.
REQ-012 conditioning_out  output  NUM_BITS  {led0, sig_pc_sw_ctl, himux2[3:0], himux[3:0], azmux[3:0]}, MSB first.
REQ-013 sample_sig  output  1  one-clock strobe, signal sample valid.
REQ-014 sample_zero  output  1  one-clock strobe, zero sample valid.
REQ-015 interrupt_out  output  1  sticky, AZ cycle complete.
REQ-016 sample_count  output  8  completed AZ cycles, modulo 256.

Function
REQ-017 States IDLE, SIG_SETTLE, SIG_INT, ZERO_SETTLE, ZERO_INT; all outputs registered, changing on the edge that enters a state.
REQ-018 Config (azmux_sig, azmux_zero, himux_sel, himux2_sel, settle_count, int_count) latched on every entry to SIG_SETTLE; input changes mid-cycle have no effect until next cycle.
REQ-019 Phase length = latched count clocks; count 0 treated as 1.
REQ-020 IDLE: azmux=4'b0000 (off), himux/himux2 = last latched values, pc=0, led0=0; run=1 -> SIG_SETTLE next edge.
REQ-021 SIG_SETTLE: azmux=azmux_sig, pc=0, led0=1; after settle length -> SIG_INT.
REQ-022 SIG_INT: azmux=azmux_sig, pc=1, led0=1; after int length -> ZERO_SETTLE.
REQ-023 ZERO_SETTLE: azmux=azmux_zero, pc=0, led0=0; after settle length -> ZERO_INT.
REQ-024 ZERO_INT: azmux=azmux_zero, pc=0, led0=0; after int length -> SIG_SETTLE if run=1, else IDLE.
REQ-025 sample_sig high exactly the first clock of ZERO_SETTLE; sample_zero high exactly the first clock after ZERO_INT ends.
REQ-026 sample_count increments on the sample_zero clock; 255 wraps to 0.
REQ-027 interrupt_out set on the sample_zero clock; cleared on the clock after ack=1; simultaneous set and ack -> stays set.
REQ-028 run deassert mid-cycle: current cycle completes fully, including strobes and interrupt; no partial cycle.
REQ-029 AZ cycle period = 2*settle + 2*int clocks (after clamping), no idle gap when run held high.
REQ-030 himux/himux2 fields constant for the whole cycle; only azmux, pc, led0 toggle inside a cycle.

Reset
REQ-031 reset_n=0 forces IDLE immediately, regardless of state or clock.
REQ-032 During and after reset: conditioning_out=0, sample_sig=0, sample_zero=0, interrupt_out=0, sample_count=0, latched config=0.
REQ-033 Reset mid-cycle aborts without strobes; first post-reset cycle starts from SIG_SETTLE with freshly latched config.

Verification
REQ-034 settle=2, int=3, azmux_sig=4'b1001, azmux_zero=4'b1011, himux=4'b1001, himux2=4'b1000, run=1 -> azmux 1001 for 5 clocks (pc 0,0,1,1,1), 1011 for 5 clocks, sample_sig at clock 6, sample_zero at clock 11, period 10.
REQ-035 settle=0, int=0, run=1 -> each phase 1 clock, period 4, sample_count +1 every 4 clocks.
REQ-036 run dropped during SIG_INT of cycle 1 -> cycle 1 completes, sample_zero and interrupt_out fire once, then IDLE with azmux=0, led0=0.
REQ-037 ack asserted on the same clock interrupt_out is set -> interrupt_out remains 1; ack next clock -> 0.
REQ-038 reset_n pulsed low during ZERO_SETTLE -> all outputs 0 asynchronously, no sample_zero, sample_count=0.
REQ-039 Run 256 cycles -> sample_count returns to 0, interrupt_out set each cycle.

Source files
------------

// File: rtl/az_sequencer.sv
// Auto-zero measurement sequencer: walks signal settle/integrate and zero settle/integrate
// phases, driving the analog mux word and issuing sample strobes and a sticky interrupt.
module az_sequencer #(
    parameter int NUM_BITS = 14,
    parameter int CNT_W    = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [3:0]          azmux_sig,
    input  logic [3:0]          azmux_zero,
    input  logic [3:0]          himux_sel,
    input  logic [3:0]          himux2_sel,
    input  logic [CNT_W-1:0]    settle_count,
    input  logic [CNT_W-1:0]    int_count,
    input  logic                ack,
    output logic [NUM_BITS-1:0] conditioning_out,
    output logic                sample_sig,
    output logic                sample_zero,
    output logic                interrupt_out,
    output logic [7:0]          sample_count
);

    typedef enum logic [2:0] {
        IDLE,
        SIG_SETTLE,
        SIG_INT,
        ZERO_SETTLE,
        ZERO_INT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             phase_done;
    logic             enter_cycle;

    logic [3:0]       cfg_az_sig;
    logic [3:0]       cfg_az_zero;
    logic [3:0]       cfg_himux;
    logic [3:0]       cfg_himux2;
    logic [CNT_W-1:0] cfg_settle;
    logic [CNT_W-1:0] cfg_int;

    logic [3:0]       eff_az_sig;
    logic [3:0]       eff_az_zero;
    logic [3:0]       eff_himux;
    logic [3:0]       eff_himux2;
    logic [CNT_W-1:0] eff_settle;
    logic [CNT_W-1:0] eff_int;
    logic [CNT_W-1:0] settle_m1;
    logic [CNT_W-1:0] int_m1;

    logic [13:0]      cond_q;
    logic [13:0]      cond_next;
    logic             sample_sig_next;
    logic             sample_zero_next;
    logic             irq_next;

    assign phase_done  = (cnt == '0);
    assign enter_cycle = (next_state == SIG_SETTLE) && (state != SIG_SETTLE);

    // On the edge that starts a cycle the incoming inputs are used directly, since they are
    // being latched on that same edge; everywhere else the latched copy is authoritative.
    assign eff_az_sig  = enter_cycle ? azmux_sig    : cfg_az_sig;
    assign eff_az_zero = enter_cycle ? azmux_zero   : cfg_az_zero;
    assign eff_himux   = enter_cycle ? himux_sel    : cfg_himux;
    assign eff_himux2  = enter_cycle ? himux2_sel   : cfg_himux2;
    assign eff_settle  = enter_cycle ? settle_count : cfg_settle;
    assign eff_int     = enter_cycle ? int_count    : cfg_int;
    assign settle_m1   = (eff_settle == '0) ? '0 : eff_settle - CNT_W'(1);
    assign int_m1      = (eff_int == '0)    ? '0 : eff_int - CNT_W'(1);

    assign conditioning_out = NUM_BITS'(cond_q);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (run)        next_state = SIG_SETTLE;
            SIG_SETTLE:  if (phase_done) next_state = SIG_INT;
            SIG_INT:     if (phase_done) next_state = ZERO_SETTLE;
            ZERO_SETTLE: if (phase_done) next_state = ZERO_INT;
            ZERO_INT:    if (phase_done) next_state = run ? SIG_SETTLE : IDLE;
            default:                     next_state = IDLE;
        endcase

        // Counter holds remaining clocks minus one in the current phase.
        cnt_next = cnt;
        if (next_state != state) begin
            case (next_state)
                SIG_SETTLE, ZERO_SETTLE: cnt_next = settle_m1;
                SIG_INT, ZERO_INT:       cnt_next = int_m1;
                default:                 cnt_next = '0;
            endcase
        end else if (!phase_done) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_comb begin
        logic [3:0] az;
        logic       pc;
        logic       led;
        az  = 4'b0000;
        pc  = 1'b0;
        led = 1'b0;
        case (next_state)
            SIG_SETTLE:  begin az = eff_az_sig;  led = 1'b1; end
            SIG_INT:     begin az = eff_az_sig;  led = 1'b1; pc = 1'b1; end
            ZERO_SETTLE: az = eff_az_zero;
            ZERO_INT:    az = eff_az_zero;
            default:     az = 4'b0000;
        endcase
        cond_next        = {led, pc, eff_himux2, eff_himux, az};
        sample_sig_next  = (state == SIG_INT) && (next_state == ZERO_SETTLE);
        sample_zero_next = (state == ZERO_INT) && phase_done;
        irq_next         = sample_zero_next | (interrupt_out & ~ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cfg_az_sig    <= '0;
            cfg_az_zero   <= '0;
            cfg_himux     <= '0;
            cfg_himux2    <= '0;
            cfg_settle    <= '0;
            cfg_int       <= '0;
            cond_q        <= '0;
            sample_sig    <= 1'b0;
            sample_zero   <= 1'b0;
            interrupt_out <= 1'b0;
            sample_count  <= '0;
        end else begin
            state         <= next_state;
            cnt           <= cnt_next;
            cond_q        <= cond_next;
            sample_sig    <= sample_sig_next;
            sample_zero   <= sample_zero_next;
            interrupt_out <= irq_next;
            sample_count  <= sample_count + 8'(sample_zero_next);
            if (enter_cycle) begin
                cfg_az_sig  <= azmux_sig;
                cfg_az_zero <= azmux_zero;
                cfg_himux   <= himux_sel;
                cfg_himux2  <= himux2_sel;
                cfg_settle  <= settle_count;
                cfg_int     <= int_count;
            end
        end
    end

endmodule

// File: tb/tb_az_sequencer.sv
// Directed bench for az_sequencer: phase timing, strobes, interrupt/ack, reset abort, count wrap.
module tb_az_sequencer;

    localparam int NUM_BITS = 14;
    localparam int CNT_W    = 24;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                run;
    logic [3:0]          azmux_sig;
    logic [3:0]          azmux_zero;
    logic [3:0]          himux_sel;
    logic [3:0]          himux2_sel;
    logic [CNT_W-1:0]    settle_count;
    logic [CNT_W-1:0]    int_count;
    logic                ack;
    logic [NUM_BITS-1:0] conditioning_out;
    logic                sample_sig;
    logic                sample_zero;
    logic                interrupt_out;
    logic [7:0]          sample_count;

    int checks = 0;
    int errors = 0;

    az_sequencer #(.NUM_BITS(NUM_BITS), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .run              (run),
        .azmux_sig        (azmux_sig),
        .azmux_zero       (azmux_zero),
        .himux_sel        (himux_sel),
        .himux2_sel       (himux2_sel),
        .settle_count     (settle_count),
        .int_count        (int_count),
        .ack              (ack),
        .conditioning_out (conditioning_out),
        .sample_sig       (sample_sig),
        .sample_zero      (sample_zero),
        .interrupt_out    (interrupt_out),
        .sample_count     (sample_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] mk(input logic led, input logic pc, input logic [3:0] h2,
                                       input logic [3:0] h, input logic [3:0] az);
        return {led, pc, h2, h, az};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; ack = 1'b0;
        azmux_sig = 4'b1111; azmux_zero = 4'b1111; himux_sel = 4'b1111; himux2_sel = 4'b1111;
        settle_count = 24'd5; int_count = 24'd5;
        #3;
        checks++;
        if (conditioning_out !== 14'h0) begin errors++; $display("[TB] FAIL reset_cond got %h exp %h", conditioning_out, 14'h0); end
        checks++;
        if ({sample_sig, sample_zero, interrupt_out} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {sample_sig, sample_zero, interrupt_out}); end
        checks++;
        if (sample_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", sample_count); end
        step();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (conditioning_out !== 14'h0) begin errors++; $display("[TB] FAIL idle_after_reset got %h exp %h", conditioning_out, 14'h0); end
    endtask

    task automatic test_basic_cycle();
        logic [13:0] s_set, s_int, z_any, idle_v, exp_c;
        int p;
        s_set  = mk(1'b1, 1'b0, 4'b1000, 4'b1001, 4'b1001);
        s_int  = mk(1'b1, 1'b1, 4'b1000, 4'b1001, 4'b1001);
        z_any  = mk(1'b0, 1'b0, 4'b1000, 4'b1001, 4'b1011);
        idle_v = mk(1'b0, 1'b0, 4'b1000, 4'b1001, 4'b0000);
        settle_count = 24'd2; int_count = 24'd3;
        azmux_sig = 4'b1001; azmux_zero = 4'b1011; himux_sel = 4'b1001; himux2_sel = 4'b1000;
        run = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            if (k == 3)  begin azmux_sig = 4'b0110; himux_sel = 4'b0000; int_count = 24'd9; end
            if (k == 11) begin azmux_sig = 4'b1001; himux_sel = 4'b1001; int_count = 24'd3; end
            if (k == 14) run = 1'b0;
            step();
            p = (k - 1) % 10;
            if (k == 21)   exp_c = idle_v;
            else if (p < 2) exp_c = s_set;
            else if (p < 5) exp_c = s_int;
            else            exp_c = z_any;
            checks++;
            if (conditioning_out !== exp_c) begin errors++; $display("[TB] FAIL basic_cond k=%0d got %b exp %b", k, conditioning_out, exp_c); end
            checks++;
            if (sample_sig !== (k == 6 || k == 16)) begin errors++; $display("[TB] FAIL basic_sample_sig k=%0d got %b exp %b", k, sample_sig, (k == 6 || k == 16)); end
            checks++;
            if (sample_zero !== (k == 11 || k == 21)) begin errors++; $display("[TB] FAIL basic_sample_zero k=%0d got %b exp %b", k, sample_zero, (k == 11 || k == 21)); end
            if (k == 10 || k == 11 || k == 21) begin
                checks++;
                if (sample_count !== ((k >= 21) ? 8'd2 : (k >= 11) ? 8'd1 : 8'd0)) begin errors++; $display("[TB] FAIL basic_count k=%0d got %0d", k, sample_count); end
                checks++;
                if (interrupt_out !== (k >= 11)) begin errors++; $display("[TB] FAIL basic_irq k=%0d got %b exp %b", k, interrupt_out, (k >= 11)); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (conditioning_out !== idle_v || sample_zero !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold got %b/%b exp %b/0", conditioning_out, sample_zero, idle_v); end
        end
    endtask

    task automatic test_fast_ack();
        logic [13:0] exp_c;
        logic        exp_irq;
        logic [7:0]  exp_cnt;
        int p;
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (interrupt_out !== 1'b0) begin errors++; $display("[TB] FAIL ack_clear got %b exp 0", interrupt_out); end
        settle_count = 24'd0; int_count = 24'd0;
        azmux_sig = 4'b0011; azmux_zero = 4'b0101; himux_sel = 4'b0110; himux2_sel = 4'b0001;
        run = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (k == 5)  ack = 1'b1;
            if (k == 7)  ack = 1'b0;
            if (k == 13) run = 1'b0;
            step();
            p = (k - 1) % 4;
            if (k == 13)    exp_c = mk(1'b0, 1'b0, 4'b0001, 4'b0110, 4'b0000);
            else if (p == 0) exp_c = mk(1'b1, 1'b0, 4'b0001, 4'b0110, 4'b0011);
            else if (p == 1) exp_c = mk(1'b1, 1'b1, 4'b0001, 4'b0110, 4'b0011);
            else             exp_c = mk(1'b0, 1'b0, 4'b0001, 4'b0110, 4'b0101);
            exp_irq = (k == 5) || (k >= 9);
            exp_cnt = 8'd2 + 8'(k >= 5) + 8'(k >= 9) + 8'(k >= 13);
            checks++;
            if (conditioning_out !== exp_c) begin errors++; $display("[TB] FAIL fast_cond k=%0d got %b exp %b", k, conditioning_out, exp_c); end
            checks++;
            if (sample_sig !== (p == 2 && k != 13)) begin errors++; $display("[TB] FAIL fast_sample_sig k=%0d got %b", k, sample_sig); end
            checks++;
            if (sample_zero !== (k == 5 || k == 9 || k == 13)) begin errors++; $display("[TB] FAIL fast_sample_zero k=%0d got %b", k, sample_zero); end
            checks++;
            if (sample_count !== exp_cnt) begin errors++; $display("[TB] FAIL fast_count k=%0d got %0d exp %0d", k, sample_count, exp_cnt); end
            checks++;
            if (interrupt_out !== exp_irq) begin errors++; $display("[TB] FAIL fast_irq k=%0d got %b exp %b", k, interrupt_out, exp_irq); end
        end
    endtask

    task automatic test_reset_mid_cycle();
        settle_count = 24'd2; int_count = 24'd3;
        azmux_sig = 4'b1001; azmux_zero = 4'b1011; himux_sel = 4'b1001; himux2_sel = 4'b1000;
        run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (sample_sig !== 1'b1) begin errors++; $display("[TB] FAIL mid_sample_sig got %b exp 1", sample_sig); end
            end
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (conditioning_out !== 14'h0) begin errors++; $display("[TB] FAIL async_reset_cond got %h exp 0", conditioning_out); end
        checks++;
        if ({sample_sig, sample_zero, interrupt_out} !== 3'b000 || sample_count !== 8'd0) begin
            errors++; $display("[TB] FAIL async_reset_flags got %b cnt %0d exp 000 cnt 0", {sample_sig, sample_zero, interrupt_out}, sample_count);
        end
        azmux_sig = 4'b1100; azmux_zero = 4'b1110; himux_sel = 4'b0011; himux2_sel = 4'b0101;
        step();
        checks++;
        if (conditioning_out !== 14'h0 || sample_zero !== 1'b0) begin errors++; $display("[TB] FAIL held_reset got %h/%b exp 0/0", conditioning_out, sample_zero); end
        reset_n = 1'b1;
        step();
        checks++;
        if (conditioning_out !== mk(1'b1, 1'b0, 4'b0101, 4'b0011, 4'b1100)) begin
            errors++; $display("[TB] FAIL post_reset_cond got %b exp %b", conditioning_out, mk(1'b1, 1'b0, 4'b0101, 4'b0011, 4'b1100));
        end
        checks++;
        if (sample_zero !== 1'b0 || sample_count !== 8'd0) begin errors++; $display("[TB] FAIL post_reset_zero got %b cnt %0d exp 0 cnt 0", sample_zero, sample_count); end
        reset_n = 1'b0;
        run = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        int pulses;
        int irq_bad;
        pulses = 0;
        irq_bad = 0;
        settle_count = 24'd0; int_count = 24'd0;
        ack = 1'b1;
        run = 1'b1;
        for (int k = 1; k <= 1025; k++) begin
            step();
            if (sample_zero === 1'b1) pulses++;
            if (interrupt_out !== sample_zero) irq_bad++;
            if (k == 1021) begin
                checks++;
                if (sample_count !== 8'd255 || sample_zero !== 1'b1) begin errors++; $display("[TB] FAIL wrap_255 got %0d/%b exp 255/1", sample_count, sample_zero); end
            end
        end
        checks++;
        if (pulses != 256) begin errors++; $display("[TB] FAIL wrap_pulses got %0d exp 256", pulses); end
        checks++;
        if (sample_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_count got %0d exp 0", sample_count); end
        checks++;
        if (irq_bad != 0) begin errors++; $display("[TB] FAIL wrap_irq_track got %0d bad clocks exp 0", irq_bad); end
        run = 1'b0;
        ack = 1'b0;
        for (int k = 0; k < 6; k++) step();
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_fast_ack();
        test_reset_mid_cycle();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
